conv_encoder_framer: RTL and testbench

- Framed rate-1/2 convolutional encoder: the transmit end feeding the Viterbi decoder's input.
- Accepts a serial payload bit stream under a valid/ready handshake and emits one 2-bit code symbol per accepted bit.
- After every FRAME_LEN payload bits it appends K-1 zero tail bits, so the trellis returns to state 0 and the decoder can terminate each frame cleanly.
- Sits between the bit source and the channel/error-injection stage.

---
 rtl/conv_encoder_framer.sv | 104 ++++++++++
 tb/tb_conv_encoder_framer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_framer.sv
// Framed rate-1/2 convolutional encoder: one registered {g0,g1} symbol per accepted
// payload bit, followed by K-1 zero tail symbols that flush the trellis to state 0.
module conv_encoder_framer #(
  parameter int             K         = 3,
  parameter logic [K-1:0]   G0        = 3'b111,
  parameter logic [K-1:0]   G1        = 3'b101,
  parameter int             FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       d_in,
  output logic       ready_o,
  output logic       valid_o,
  output logic [1:0] d_out,
  output logic       sof_o,
  output logic       eof_o
);

  localparam int BCW = $clog2(FRAME_LEN + 1);
  localparam int TCW = $clog2(K);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(FRAME_LEN - 1);
  localparam logic [TCW-1:0] LAST_TAIL = TCW'(K - 2);

  logic [1:0]     state;
  logic [K-2:0]   sr;
  logic [BCW-1:0] bit_ct;
  logic [TCW-1:0] tail_ct;

  logic           accept;
  logic           bit_in;
  logic [K-1:0]   v;
  logic [1:0]     sym;

  assign ready_o = !rst && (state != TAIL);
  assign accept  = enable_i && ready_o;

  // v[K-1:1] is also the next shift-register contents: the new bit enters at the top.
  always_comb begin
    bit_in = (state == TAIL) ? 1'b0 : d_in;
    v      = {bit_in, sr};
    sym    = {^(v & G0), ^(v & G1)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_ct  <= '0;
      tail_ct <= '0;
      valid_o <= 1'b0;
      d_out   <= '0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            valid_o <= 1'b1;
            d_out   <= sym;
            sr      <= v[K-1:1];
            sof_o   <= 1'b1;
            bit_ct  <= BCW'(1);
            tail_ct <= '0;
            state   <= (FRAME_LEN == 1) ? TAIL : DATA;
          end
        end
        DATA: begin
          if (accept) begin
            valid_o <= 1'b1;
            d_out   <= sym;
            sr      <= v[K-1:1];
            bit_ct  <= bit_ct + 1'b1;
            if (bit_ct == LAST_BIT) begin
              tail_ct <= '0;
              state   <= TAIL;
            end
          end
        end
        TAIL: begin
          valid_o <= 1'b1;
          d_out   <= sym;
          sr      <= v[K-1:1];
          tail_ct <= tail_ct + 1'b1;
          if (tail_ct == LAST_TAIL) begin
            eof_o  <= 1'b1;
            bit_ct <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Bench for conv_encoder_framer: frame-position reference model plus directed and
// random stimulus on a default instance and a FRAME_LEN=1 instance.
module tb_conv_encoder_framer;

  localparam int FL = 8;
  localparam int K  = 3;
  localparam int SYMS = FL + K - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_i = 1'b0, d_in = 1'b0;
  logic ready_o, valid_o, sof_o, eof_o;
  logic [1:0] d_out;
  logic en1 = 1'b0, b1 = 1'b0;
  logic ready1, valid1, sof1, eof1;
  logic [1:0] dout1;

  always #5 clk = ~clk;

  conv_encoder_framer dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .ready_o(ready_o),
    .valid_o(valid_o), .d_out(d_out), .sof_o(sof_o), .eof_o(eof_o)
  );

  conv_encoder_framer #(.FRAME_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .enable_i(en1), .d_in(b1), .ready_o(ready1),
    .valid_o(valid1), .d_out(dout1), .sof_o(sof1), .eof_o(eof1)
  );

  int checks = 0, passed = 0, fails = 0;

  // Reference model: position within the current frame and the bits encoded so far in it.
  logic [2:0] g0m = 3'b111;
  logic [2:0] g1m = 3'b101;
  logic hist [0:SYMS-1];
  int   pos = 0;
  int   frames_exp = 0, eof_seen = 0;
  logic [1:0] last_dout = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol at frame position p: convolution of the frame's bits (zero before frame start).
  function automatic logic [1:0] ref_sym(input int p);
    logic s0 = 1'b0, s1 = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (p - j >= 0) begin
        s0 ^= hist[p-j] & g0m[K-1-j];
        s1 ^= hist[p-j] & g1m[K-1-j];
      end
    end
    return {s0, s1};
  endfunction

  task automatic step(input logic en, input logic d, input logic e1, input logic d1);
    logic exp_ready, emit, last;
    logic [1:0] es;
    logic esof;
    es = 2'b00; esof = 1'b0; last = 1'b0;
    @(negedge clk);
    enable_i = en; d_in = d; en1 = e1; b1 = d1;
    #1;
    exp_ready = (pos < FL);
    chk("ready", 32'(ready_o), 32'(exp_ready));
    emit = exp_ready ? en : 1'b1;
    if (emit) begin
      hist[pos] = exp_ready ? d : 1'b0;
      es   = ref_sym(pos);
      esof = (pos == 0);
      last = (pos == SYMS - 1);
      pos  = last ? 0 : pos + 1;
      if (last) frames_exp++;
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(valid_o), 32'(emit));
    if (emit) begin
      chk("d_out", 32'(d_out), 32'(es));
      chk("sof", 32'(sof_o), 32'(esof));
      chk("eof", 32'(eof_o), 32'(last));
      last_dout = es;
    end else begin
      chk("d_out_hold", 32'(d_out), 32'(last_dout));
      chk("sof_idle", 32'(sof_o), 32'(1'b0));
      chk("eof_idle", 32'(eof_o), 32'(1'b0));
    end
    if (eof_o === 1'b1) eof_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable_i = 1'b0; en1 = 1'b0;
    #1;
    chk("ready_in_rst", 32'(ready_o), 32'(1'b0));
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'(1'b0));
    chk("rst_dout", 32'(d_out), 32'(2'b00));
    chk("rst_sof", 32'(sof_o), 32'(1'b0));
    chk("rst_eof", 32'(eof_o), 32'(1'b0));
    chk("rst_valid1", 32'(valid1), 32'(1'b0));
    pos = 0;
    last_dout = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(ready_o), 32'(1'b1));
  endtask

  initial begin
    logic [7:0] pay1;
    logic [1:0] tbl1 [0:9];
    logic [1:0] tbl2 [0:9];
    logic [1:0] tbl6 [0:5];
    pay1 = 8'b1011_0000;
    tbl1 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl2 = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    tbl6 = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11};

    do_reset();

    // Scenario 1: consecutive payload, then the two tail cycles.
    for (int i = 0; i < FL; i++) begin
      step(1'b1, pay1[7-i], 1'b0, 1'b0);
      chk("s1_sym", 32'(d_out), 32'(tbl1[i]));
    end
    for (int i = FL; i < SYMS; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s1_tail", 32'(d_out), 32'(tbl1[i]));
    end
    chk("s1_eof", 32'(eof_o), 32'(1'b1));

    // Scenario 2: all ones, then a new frame starting with 1 must see a cleared register.
    for (int i = 0; i < SYMS; i++) begin
      step(i < FL, 1'b1, 1'b0, 1'b0);
      chk("s2_sym", 32'(d_out), 32'(tbl2[i]));
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s2_next_sof", 32'({sof_o, d_out}), 32'(3'b111));
    for (int i = 1; i < SYMS; i++) step(i < FL, 1'b0, 1'b0, 1'b0);

    // Scenario 3: scenario 1 payload with random gaps.
    for (int i = 0; i < FL; i++) begin
      int gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, pay1[7-i], 1'b0, 1'b0);
      chk("s3_sym", 32'(d_out), 32'(tbl1[i]));
    end
    for (int i = FL; i < SYMS; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("s3_tail", 32'(d_out), 32'(tbl1[i]));
    end

    // Scenario 4: enable held high with d_in=1 through several tails.
    for (int i = 0; i < 3 * SYMS; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s4_frames", 32'(eof_seen), 32'(frames_exp));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("s4_sof_sym", 32'({sof_o, d_out}), 32'(3'b111));
    for (int i = 1; i < SYMS; i++) step(i < FL, 1'b0, 1'b0, 1'b0);

    // Scenario 5: reset after 4 bits, then scenario 1 again.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < SYMS; i++) begin
      step(i < FL, (i < FL) ? pay1[7-(i%FL)] : 1'b0, 1'b0, 1'b0);
      chk("s5_sym", 32'(d_out), 32'(tbl1[i]));
    end

    // Random traffic against the model.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("rand_frames", 32'(eof_seen), 32'(frames_exp));

    // Scenario 6: FRAME_LEN=1 instance, two frames back-to-back.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("s6_valid", 32'(valid1), 32'(1'b1));
      chk("s6_sym", 32'(dout1), 32'(tbl6[i]));
      chk("s6_sof", 32'(sof1), 32'(i % 3 == 0));
      chk("s6_eof", 32'(eof1), 32'(i % 3 == 2));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("s6_idle", 32'(valid1), 32'(1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
